// File: rtl/geofence_feeder_if.sv
// rtl/geofence_feeder_if.sv - stream, core and result signals of the geofence feeder
//
// Groups the three handshakes around the feeder:
//   in_*   : upstream point stream (valid/ready, X/Y)
//   gf_*   : direct drive of the geofence core (reset, X/Y) and its result strobe
//   res_*  : per-frame result (valid/ready, inside flag, frame id, watchdog error)
// master : the feeder side; slave : the environment (upstream source, core, result sink).
interface geofence_feeder_if #(
    parameter int CW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_x;
    logic [CW-1:0] in_y;

    logic          gf_reset;
    logic [CW-1:0] gf_x;
    logic [CW-1:0] gf_y;
    logic          gf_valid;
    logic          gf_is_inside;

    logic          res_valid;
    logic          res_ready;
    logic          res_inside;
    logic [7:0]    res_frame_id;
    logic          res_err;

    modport master (
        input  in_valid, in_x, in_y, gf_valid, gf_is_inside, res_ready,
        output in_ready, gf_reset, gf_x, gf_y, res_valid, res_inside, res_frame_id, res_err
    );

    modport slave (
        output in_valid, in_x, in_y, gf_valid, gf_is_inside, res_ready,
        input  in_ready, gf_reset, gf_x, gf_y, res_valid, res_inside, res_frame_id, res_err
    );
endinterface

// File: rtl/geofence_feeder.sv
// rtl/geofence_feeder.sv - ping-pong frame buffer and sequencer in front of the geofence core
//
// Collects 7-point frames (object first, then 6 sensors) from the point stream into two
// banks, streams each full frame into the core on 7 consecutive cycles (the core cannot
// stall), holds the core in reset while nothing is ready, and returns one result per frame.
//
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : geofence_feeder_if.master (in_*, gf_*, res_* signal groups)
//
// Optional feature macro: GEOFENCE_FEEDER_WDOG_EN
//   defined   : watchdog aborts a frame whose result has not arrived TIMEOUT cycles into
//               WAIT, posting res_err=1
//   undefined : WAIT waits indefinitely, res_err is constant 0
module geofence_feeder #(
    parameter int CW = 10
`ifdef GEOFENCE_FEEDER_WDOG_EN
    ,
    parameter int TIMEOUT = 63
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    geofence_feeder_if.master   bus
);
    localparam int NPTS = 7;
    localparam logic [2:0] LAST = 3'(NPTS - 1);

    typedef enum logic [1:0] {HOLD, STREAM, WAIT} state_t;

    state_t          state_q, state_d;
    logic [2*CW-1:0] mem_q [2][NPTS];
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [2:0]      wr_idx_q, wr_idx_d;
    logic [2:0]      k_q, k_d;
    logic            gf_reset_q, gf_reset_d;
    logic [CW-1:0]   gf_x_q, gf_x_d;
    logic [CW-1:0]   gf_y_q, gf_y_d;
    logic            res_valid_q, res_valid_d;
    logic            res_inside_q, res_inside_d;
    logic [7:0]      res_frame_id_q, res_frame_id_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

`ifdef GEOFENCE_FEEDER_WDOG_EN
    logic [7:0]      wdog_q, wdog_d;
    logic            res_err_q, res_err_d;
    logic            timeout;
`endif

    logic            accept;
    logic            start;
    logic            load;
    logic            post;
    logic [2:0]      rd_idx;

    assign accept = bus.in_valid && !full_q[wr_bank_q];
    // A frame may only start when its result will have somewhere to go.
    assign start  = full_q[rd_bank_q] && (!res_valid_q || bus.res_ready);

    always_comb begin
        state_d        = state_q;
        full_d         = full_q;
        wr_bank_d      = wr_bank_q;
        rd_bank_d      = rd_bank_q;
        wr_idx_d       = wr_idx_q;
        k_d            = k_q;
        gf_reset_d     = gf_reset_q;
        gf_x_d         = gf_x_q;
        gf_y_d         = gf_y_q;
        res_valid_d    = res_valid_q;
        res_inside_d   = res_inside_q;
        res_frame_id_d = res_frame_id_q;
        frame_cnt_d    = frame_cnt_q;
        load           = 1'b0;
        post           = 1'b0;
        rd_idx         = 3'd0;
`ifdef GEOFENCE_FEEDER_WDOG_EN
        wdog_d         = wdog_q;
        res_err_d      = res_err_q;
        timeout        = 1'b0;
`endif

        if (accept) begin
            if (wr_idx_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = 3'd0;
            end else begin
                wr_idx_d = wr_idx_q + 3'd1;
            end
        end

        // gf_x/gf_y are loaded one edge ahead so point k is on the wires in stream cycle k.
        case (state_q)
            HOLD: begin
                gf_reset_d = 1'b1;
                if (start) begin
                    state_d    = STREAM;
                    k_d        = 3'd0;
                    gf_reset_d = 1'b0;
                    load       = 1'b1;
                end
            end
            STREAM: begin
                gf_reset_d = 1'b0;
                if (k_q == LAST) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    state_d           = WAIT;
`ifdef GEOFENCE_FEEDER_WDOG_EN
                    wdog_d            = 8'd0;
`endif
                end else begin
                    k_d    = k_q + 3'd1;
                    rd_idx = k_q + 3'd1;
                    load   = 1'b1;
                end
            end
            WAIT: begin
                if (bus.gf_valid) begin
                    post = 1'b1;
                    // rd_bank already points at the next bank, so a back-to-back frame
                    // starts while the core sits in its first read cycle.
                    if (start) begin
                        state_d    = STREAM;
                        k_d        = 3'd0;
                        gf_reset_d = 1'b0;
                        load       = 1'b1;
                    end else begin
                        state_d    = HOLD;
                        gf_reset_d = 1'b1;
                    end
                end
`ifdef GEOFENCE_FEEDER_WDOG_EN
                else if (wdog_q == 8'(TIMEOUT - 1)) begin
                    post       = 1'b1;
                    timeout    = 1'b1;
                    state_d    = HOLD;
                    gf_reset_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d    = HOLD;
                gf_reset_d = 1'b1;
            end
        endcase

        if (load) begin
            {gf_x_d, gf_y_d} = mem_q[rd_bank_q][rd_idx];
        end

        if (post) begin
            res_valid_d    = 1'b1;
            res_frame_id_d = frame_cnt_q;
            frame_cnt_d    = frame_cnt_q + 8'd1;
`ifdef GEOFENCE_FEEDER_WDOG_EN
            res_inside_d   = timeout ? 1'b0 : bus.gf_is_inside;
            res_err_d      = timeout;
`else
            res_inside_d   = bus.gf_is_inside;
`endif
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HOLD;
            full_q         <= 2'b00;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            wr_idx_q       <= 3'd0;
            k_q            <= 3'd0;
            gf_reset_q     <= 1'b1;
            gf_x_q         <= '0;
            gf_y_q         <= '0;
            res_valid_q    <= 1'b0;
            res_inside_q   <= 1'b0;
            res_frame_id_q <= 8'd0;
            frame_cnt_q    <= 8'd0;
`ifdef GEOFENCE_FEEDER_WDOG_EN
            wdog_q         <= 8'd0;
            res_err_q      <= 1'b0;
`endif
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NPTS; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else begin
            state_q        <= state_d;
            full_q         <= full_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            wr_idx_q       <= wr_idx_d;
            k_q            <= k_d;
            gf_reset_q     <= gf_reset_d;
            gf_x_q         <= gf_x_d;
            gf_y_q         <= gf_y_d;
            res_valid_q    <= res_valid_d;
            res_inside_q   <= res_inside_d;
            res_frame_id_q <= res_frame_id_d;
            frame_cnt_q    <= frame_cnt_d;
`ifdef GEOFENCE_FEEDER_WDOG_EN
            wdog_q         <= wdog_d;
            res_err_q      <= res_err_d;
`endif
            if (accept) begin
                mem_q[wr_bank_q][wr_idx_q] <= {bus.in_x, bus.in_y};
            end
        end
    end

    assign bus.in_ready     = !full_q[wr_bank_q];
    assign bus.gf_reset     = gf_reset_q;
    assign bus.gf_x         = gf_x_q;
    assign bus.gf_y         = gf_y_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_inside   = res_inside_q;
    assign bus.res_frame_id = res_frame_id_q;
`ifdef GEOFENCE_FEEDER_WDOG_EN
    assign bus.res_err      = res_err_q;
`else
    assign bus.res_err      = 1'b0;
`endif
endmodule

// File: tb/tb_geofence_feeder.sv
// tb/tb_geofence_feeder.sv - directed self-checking bench for geofence_feeder
module tb_geofence_feeder;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    geofence_feeder_if #(.CW(CW)) ifc ();

    geofence_feeder #(.CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.master)
    );

    always #5 clk = ~clk;

    int sx [6] = '{600, 450, 550, 400, 550, 450};
    int sy [6] = '{500, 587, 413, 500, 587, 413};

    // Stand-in core: result strobe 46 cycles after the first cycle out of reset,
    // READ_XY again the cycle after. "Inside" is decided by a box around the sensor ring.
    int              c = 0;
    bit              core_en = 1'b1;
    logic [2*CW-1:0] cap [7];

    always @(negedge clk) begin
        if (!reset_n || ifc.gf_reset) begin
            c = 0;
            ifc.gf_valid = 1'b0;
        end else begin
            if (c < 7) cap[c] = {ifc.gf_x, ifc.gf_y};
            ifc.gf_valid = (c == 46) && core_en;
            ifc.gf_is_inside = (cap[0][2*CW-1:CW] >= CW'(400)) && (cap[0][2*CW-1:CW] <= CW'(600))
                            && (cap[0][CW-1:0] >= CW'(400)) && (cap[0][CW-1:0] <= CW'(600));
            c = (c == 46) ? 0 : c + 1;
        end
    end

    task automatic push(input int x, input int y);
        int n;
        ifc.in_valid = 1'b1;
        ifc.in_x = CW'(x);
        ifc.in_y = CW'(y);
        n = 0;
        while (!ifc.in_ready && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (n >= 300) begin errors++; $display("FAIL push_timeout: in_ready stuck at %0b want 1", ifc.in_ready); end
        @(negedge clk);
    endtask

    task automatic push_pts(input int ox, input int oy);
        push(ox, oy);
        for (int i = 0; i < 6; i++) push(sx[i], sy[i]);
    endtask

    task automatic push_frame(input int ox, input int oy);
        push_pts(ox, oy);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_stream();
        int n;
        n = 0;
        while (ifc.gf_reset && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (n >= 300) begin errors++; $display("FAIL stream_timeout: gf_reset stuck at %0b want 0", ifc.gf_reset); end
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!ifc.res_valid && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL result_timeout: res_valid %0b want 1", ifc.res_valid); end
    endtask

    task automatic check_cap(input string name, input int ox, input int oy);
        int bad;
        logic [2*CW-1:0] e;
        bad = 0;
        e = {CW'(ox), CW'(oy)};
        if (cap[0] !== e) bad++;
        for (int i = 0; i < 6; i++) begin
            e = {CW'(sx[i]), CW'(sy[i])};
            if (cap[i+1] !== e) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s: %0d streamed points wrong want 0", name, bad); end
    endtask

    task automatic test_reset();
        checks++; if (ifc.gf_reset !== 1'b1) begin errors++; $display("FAIL rst_gf_reset: got %0b want 1", ifc.gf_reset); end
        checks++; if (ifc.gf_x !== '0 || ifc.gf_y !== '0) begin errors++; $display("FAIL rst_gf_xy: got %0d,%0d want 0,0", ifc.gf_x, ifc.gf_y); end
        checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", ifc.in_ready); end
        checks++; if (ifc.res_valid !== 1'b0 || ifc.res_inside !== 1'b0) begin errors++; $display("FAIL rst_res: got v=%0b i=%0b want 0,0", ifc.res_valid, ifc.res_inside); end
        checks++; if (ifc.res_frame_id !== 8'd0 || ifc.res_err !== 1'b0) begin errors++; $display("FAIL rst_id_err: got %0d,%0b want 0,0", ifc.res_frame_id, ifc.res_err); end
    endtask

    task automatic test_inside();
        int n;
        ifc.res_ready = 1'b1;
        push_frame(500, 500);
        wait_stream();
        checks++; if (ifc.gf_x !== CW'(500) || ifc.gf_y !== CW'(500)) begin errors++; $display("FAIL in_first_pt: got %0d,%0d want 500,500", ifc.gf_x, ifc.gf_y); end
        wait_res(n);
        checks++; if (n != 47) begin errors++; $display("FAIL in_latency: got %0d want 47", n); end
        checks++; if (ifc.res_inside !== 1'b1) begin errors++; $display("FAIL in_inside: got %0b want 1", ifc.res_inside); end
        checks++; if (ifc.res_frame_id !== 8'd0) begin errors++; $display("FAIL in_id: got %0d want 0", ifc.res_frame_id); end
        checks++; if (ifc.res_err !== 1'b0) begin errors++; $display("FAIL in_err: got %0b want 0", ifc.res_err); end
        checks++; if (ifc.gf_reset !== 1'b1) begin errors++; $display("FAIL in_back_hold: got %0b want 1", ifc.gf_reset); end
        check_cap("in_points", 500, 500);
        @(negedge clk);
        checks++; if (ifc.res_valid !== 1'b0) begin errors++; $display("FAIL in_res_clear: got %0b want 0", ifc.res_valid); end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        #1 ifc.gf_valid = 1'b1;
        @(posedge clk);
        #1 ifc.gf_valid = 1'b0;
        @(negedge clk);
        checks++; if (ifc.res_valid !== 1'b0) begin errors++; $display("FAIL spur_res: got %0b want 0", ifc.res_valid); end
        checks++; if (ifc.gf_reset !== 1'b1) begin errors++; $display("FAIL spur_hold: got %0b want 1", ifc.gf_reset); end
    endtask

    task automatic test_outside();
        int n;
        push_frame(100, 100);
        wait_stream();
        checks++; if (ifc.gf_x !== CW'(100) || ifc.gf_y !== CW'(100)) begin errors++; $display("FAIL out_first_pt: got %0d,%0d want 100,100", ifc.gf_x, ifc.gf_y); end
        wait_res(n);
        checks++; if (ifc.res_inside !== 1'b0) begin errors++; $display("FAIL out_inside: got %0b want 0", ifc.res_inside); end
        checks++; if (ifc.res_frame_id !== 8'd1) begin errors++; $display("FAIL out_id: got %0d want 1", ifc.res_frame_id); end
        check_cap("out_points", 100, 100);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, r1, r2, got, highs;
        ifc.res_ready = 1'b1;
        r1 = -1; r2 = -1; got = 0; highs = 0;
        fork
            begin
                push_pts(500, 500);
                push_pts(500, 500);
                checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %0b want 0", ifc.in_ready); end
                ifc.in_valid = 1'b0;
            end
            begin
                wait_stream();
                n = 0;
                while (got < 2 && n < 400) begin
                    @(negedge clk);
                    n++;
                    if (ifc.res_valid) begin
                        got++;
                        if (got == 1) begin
                            r1 = n;
                            checks++; if (ifc.res_frame_id !== 8'd2) begin errors++; $display("FAIL b2b_id0: got %0d want 2", ifc.res_frame_id); end
                        end else begin
                            r2 = n;
                            checks++; if (ifc.res_frame_id !== 8'd3) begin errors++; $display("FAIL b2b_id1: got %0d want 3", ifc.res_frame_id); end
                        end
                    end
                    if (got < 2 && ifc.gf_reset) highs++;
                end
            end
        join
        checks++; if (got != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", got); end
        checks++; if (r1 != 47) begin errors++; $display("FAIL b2b_lat0: got %0d want 47", r1); end
        checks++; if (r2 - r1 != 47) begin errors++; $display("FAIL b2b_gap: got %0d want 47", r2 - r1); end
        checks++; if (highs != 0) begin errors++; $display("FAIL b2b_gf_reset: got %0d high cycles want 0", highs); end
        check_cap("b2b_points", 500, 500);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        ifc.res_ready = 1'b0;
        push_frame(500, 500);
        wait_res(n);
        checks++; if (ifc.res_frame_id !== 8'd4 || ifc.res_inside !== 1'b1) begin errors++; $display("FAIL bp_res0: got id=%0d i=%0b want 4,1", ifc.res_frame_id, ifc.res_inside); end
        push_frame(100, 100);
        repeat (10) @(negedge clk);
        checks++; if (ifc.gf_reset !== 1'b1) begin errors++; $display("FAIL bp_hold: got %0b want 1", ifc.gf_reset); end
        checks++; if (ifc.res_valid !== 1'b1 || ifc.res_frame_id !== 8'd4) begin errors++; $display("FAIL bp_held: got v=%0b id=%0d want 1,4", ifc.res_valid, ifc.res_frame_id); end
        ifc.res_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifc.gf_reset !== 1'b0 || ifc.gf_x !== CW'(100)) begin errors++; $display("FAIL bp_start: got r=%0b x=%0d want 0,100", ifc.gf_reset, ifc.gf_x); end
        checks++; if (ifc.res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", ifc.res_valid); end
        wait_res(n);
        checks++; if (n != 47) begin errors++; $display("FAIL bp_latency: got %0d want 47", n); end
        checks++; if (ifc.res_frame_id !== 8'd5 || ifc.res_inside !== 1'b0) begin errors++; $display("FAIL bp_res1: got id=%0d i=%0b want 5,0", ifc.res_frame_id, ifc.res_inside); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, posts;
        ifc.res_ready = 1'b1;
        push_frame(500, 500);
        wait_stream();
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (ifc.gf_reset !== 1'b1) begin errors++; $display("FAIL rm_gf_reset: got %0b want 1", ifc.gf_reset); end
        checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %0b want 1", ifc.in_ready); end
        checks++; if (ifc.gf_x !== '0 || ifc.res_valid !== 1'b0) begin errors++; $display("FAIL rm_clear: got x=%0d v=%0b want 0,0", ifc.gf_x, ifc.res_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        posts = 0;
        repeat (60) begin @(negedge clk); if (ifc.res_valid) posts++; end
        checks++; if (posts != 0) begin errors++; $display("FAIL rm_no_result: got %0d results want 0", posts); end
        push_frame(500, 500);
        wait_stream();
        checks++; if (ifc.gf_x !== CW'(500) || ifc.gf_y !== CW'(500)) begin errors++; $display("FAIL rm_first_pt: got %0d,%0d want 500,500", ifc.gf_x, ifc.gf_y); end
        wait_res(n);
        checks++; if (ifc.res_frame_id !== 8'd0 || ifc.res_inside !== 1'b1) begin errors++; $display("FAIL rm_res: got id=%0d i=%0b want 0,1", ifc.res_frame_id, ifc.res_inside); end
        @(negedge clk);
    endtask

`ifdef GEOFENCE_FEEDER_WDOG_EN
    task automatic test_watchdog();
        int n;
        core_en = 1'b0;
        ifc.res_ready = 1'b1;
        push_frame(500, 500);
        wait_stream();
        wait_res(n);
        checks++; if (n != 70) begin errors++; $display("FAIL wd_latency: got %0d want 70", n); end
        checks++; if (ifc.res_err !== 1'b1 || ifc.res_inside !== 1'b0) begin errors++; $display("FAIL wd_res: got e=%0b i=%0b want 1,0", ifc.res_err, ifc.res_inside); end
        checks++; if (ifc.res_frame_id !== 8'd1) begin errors++; $display("FAIL wd_id: got %0d want 1", ifc.res_frame_id); end
        checks++; if (ifc.gf_reset !== 1'b1) begin errors++; $display("FAIL wd_hold: got %0b want 1", ifc.gf_reset); end
        core_en = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_x = '0;
        ifc.in_y = '0;
        ifc.res_ready = 1'b0;
        ifc.gf_valid = 1'b0;
        ifc.gf_is_inside = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_inside();
        test_spurious();
        test_outside();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef GEOFENCE_FEEDER_WDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
